pipe_adder: RTL
===============

Name: pipe_adder

Overview:
Parametrised, pipelined add/subtract unit. Generalises the 16-bit combinational full adder to WIDTH bits, split into STAGES carry-registered slices. Adds a valid/ready handshake, carry-in, subtract mode and backpressure. Sits between operand source and writeback; one operation accepted per cycle when not stalled.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of STAGES.
STAGES, 4, pipeline depth; each stage adds one SLICE = WIDTH/STAGES bit chunk.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  unit can accept a beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in (ignored when sub=1)
sub  input  1  0: A+B+cin; 1: A-B
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result, modulo 2^WIDTH
co  output  1  carry-out; for sub, 1 = no borrow (A>=B unsigned)

Behaviour:
- Reset (async, rst=1): all stage valid bits 0; out_valid=0; sum=0; co=0. in_ready=1 while rst is low and the pipe is empty.
- Advance condition: adv = !out_valid || out_ready. Whole pipe shifts one stage when adv=1 and holds all registers otherwise (global stall; bubbles are not collapsed).
- in_ready = adv, combinational. A beat is accepted when in_valid && in_ready.
- Operand conditioning at accept: bb = sub ? ~b : b; c0 = sub ? 1 : cin.
- Stage k (0..STAGES-1): adds bits [k*SLICE +: SLICE] of a and bb plus the registered carry from stage k-1 (c0 for k=0). It registers the chunk sum and the carry. Upper operand chunks travel with the beat, delayed in skew registers. Lower result chunks are delayed so that all chunks emerge aligned.
- Latency: a beat accepted at edge n appears with out_valid=1 after edge n+STAGES-1, i.e. STAGES register stages. Throughput: 1 beat/cycle with out_ready held at 1.
- co = carry out of the top slice. Result equals the combinational (a+bb+c0) mod 2^WIDTH, and co equals bit WIDTH of the same sum.
- Output hold: while out_valid && !out_ready, sum and co stay stable and no beat is accepted.
- Empty-pipe stall: if out_valid=0, the pipe advances regardless of out_ready.
- Simultaneous accept and emit are both legal in the same cycle (full throughput).
- Reset mid-operation: all in-flight beats are discarded; no output appears after reset deasserts until a new beat has traversed STAGES stages.
- Invalid stages still shift, but their data is don't-care; only the valid bits gate the output.

Optional Feature:
Macro PIPE_ADDER_OVF_EN.
- Defined: adds output port ovf (1 bit). ovf = signed two's-complement overflow of the operation, i.e. operand sign bits of a and bb equal and the result sign differs. It is registered alongside sum, resets to 0, and is held under stall.
- Undefined: no ovf port and no related logic.

Decomposition:
- Package pipe_adder_pkg holds: default WIDTH/STAGES constants; localparam SLICE derivation helper; and an elaboration-time check that WIDTH % STAGES == 0, which raises a $error otherwise.
- One sub-module, pipe_adder_slice: combinational SLICE-bit ripple adder (a, b, ci -> s, co), instantiated STAGES times via generate.

Test Plan:
- Basic (WIDTH=16, STAGES=4): a=12701, b=6027, cin=0, sub=0, out_ready=1 -> after 4 edges out_valid=1, sum=18728, co=0.
- Wrap: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, co=1. a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, co=1.
- Subtract: a=5, b=7, sub=1 -> sum=0xFFFE, co=0. a=7, b=5 -> sum=0x0002, co=1. With PIPE_ADDER_OVF_EN: a=0x7FFF, b=0xFFFF, sub=1 -> sum=0x8000, ovf=1.
- Throughput and backpressure: 8 back-to-back beats, a=(12701<<2i)%65536, b=(1027<<i)%65536+5000. Hold out_ready=0 for 3 cycles after the first result -> in_ready=0 and sum/co stable for those cycles. Afterwards all 8 results arrive in order, matching the model, with none lost or duplicated.
- Reset mid-flight: accept 3 beats, assert rst for 1 cycle -> out_valid=0 immediately and no stale result ever emerges. The next beat emerges 4 cycles after acceptance.
- Parametric: rerun the random compare of 1000 operands at WIDTH=32, STAGES=8 and at WIDTH=8, STAGES=1 (latency 1) against the model (a+bb+c0).

Source files
------------

// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: default geometry and slice helpers for the pipelined add/subtract unit
package pipe_adder_pkg;
   localparam int DEF_WIDTH  = 16;
   localparam int DEF_STAGES = 4;
   function automatic int slice_w(input int width, input int stages);
      return width / stages;
   endfunction
   function automatic bit width_ok(input int width, input int stages);
      return stages > 0 && width % stages == 0;
   endfunction
endpackage

// File: rtl/pipe_adder_slice.sv
// pipe_adder_slice: combinational N-bit ripple-carry adder chunk
module pipe_adder_slice #(
   parameter int N = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         ci,
   output logic [N-1:0] s,
   output logic         co
);
   logic [N:0] c;
   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = ci;
      for (int i = 0; i < N; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end
   assign co = c[N];
endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined add/subtract with carry-registered slices and valid/ready handshake.
// Define PIPE_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module pipe_adder
   import pipe_adder_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STAGES = DEF_STAGES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
`ifdef PIPE_ADDER_OVF_EN
   output logic             co,
   output logic             ovf
`else
   output logic             co
`endif
);
   localparam int SLICE = slice_w(WIDTH, STAGES);

   if (!width_ok(WIDTH, STAGES)) begin : g_chk
      $error("pipe_adder: WIDTH (%0d) must be a multiple of STAGES (%0d)", WIDTH, STAGES);
   end

   logic             adv;
   logic [WIDTH-1:0] bb;
   logic             c0;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;
   assign bb       = sub ? ~b : b;
   assign c0       = sub | cin;

   // Stage k consumes slice k; result chunks grow downward, operand chunks shrink upward.
   for (genvar k = 0; k < STAGES; k++) begin : g_st
      localparam int UP = WIDTH - (k + 1) * SLICE;
      logic [SLICE-1:0]         xa, xb, xs;
      logic                     xc, xco, xv, v_q, c_q;
      logic [(k+1)*SLICE-1:0]   r_q;

      pipe_adder_slice #(.N(SLICE)) u_slice (
         .a (xa),
         .b (xb),
         .ci(xc),
         .s (xs),
         .co(xco)
      );

      if (k == 0) begin : g_src
         assign xa = a[SLICE-1:0];
         assign xb = bb[SLICE-1:0];
         assign xc = c0;
         assign xv = in_valid;
         always_ff @(posedge clk or posedge rst)
            if (rst) r_q <= '0;
            else if (adv) r_q <= xs;
      end else begin : g_src
         assign xa = g_st[k-1].g_up.ua_q[SLICE-1:0];
         assign xb = g_st[k-1].g_up.ub_q[SLICE-1:0];
         assign xc = g_st[k-1].c_q;
         assign xv = g_st[k-1].v_q;
         always_ff @(posedge clk or posedge rst)
            if (rst) r_q <= '0;
            else if (adv) r_q <= {xs, g_st[k-1].r_q};
      end

      always_ff @(posedge clk or posedge rst)
         if (rst) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
         end else if (adv) begin
            v_q <= xv;
            c_q <= xco;
         end

      if (UP > 0) begin : g_up
         logic [UP-1:0] ua_q, ub_q, ua_d, ub_d;
         if (k == 0) begin : g_d
            assign ua_d = a[WIDTH-1:SLICE];
            assign ub_d = bb[WIDTH-1:SLICE];
         end else begin : g_d
            assign ua_d = g_st[k-1].g_up.ua_q[UP+SLICE-1:SLICE];
            assign ub_d = g_st[k-1].g_up.ub_q[UP+SLICE-1:SLICE];
         end
         always_ff @(posedge clk or posedge rst)
            if (rst) begin
               ua_q <= '0;
               ub_q <= '0;
            end else if (adv) begin
               ua_q <= ua_d;
               ub_q <= ub_d;
            end
      end

`ifdef PIPE_ADDER_OVF_EN
      if (k == STAGES - 1) begin : g_ovf
         logic ovf_q;
         always_ff @(posedge clk or posedge rst)
            if (rst) ovf_q <= 1'b0;
            else if (adv) ovf_q <= (xa[SLICE-1] == xb[SLICE-1]) && (xs[SLICE-1] != xa[SLICE-1]);
      end
`endif
   end

   assign out_valid = g_st[STAGES-1].v_q;
   assign sum       = g_st[STAGES-1].r_q;
   assign co        = g_st[STAGES-1].c_q;
`ifdef PIPE_ADDER_OVF_EN
   assign ovf       = g_st[STAGES-1].g_ovf.ovf_q;
`endif
endmodule
